// File: rtl/memory_dumper_pkg.sv
// Shared types and constants for the memory dumper.
// Optional feature macro: MEMORY_DUMPER_CHECKSUM_EN (adds the CSUM state).
package memory_dumper_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;

`ifdef MEMORY_DUMPER_CHECKSUM_EN
   typedef enum logic [2:0] {
      IDLE,
      REQ,
      SEND,
      CSUM,
      DONE
   } dump_state_t;
`else
   typedef enum logic [2:0] {
      IDLE,
      REQ,
      SEND,
      DONE
   } dump_state_t;
`endif

endpackage

// File: rtl/memory_dumper.sv
// memory_dumper: reads a range of 32-bit words from a memory read port and
// streams them MSB-first as bytes over the UART transmit handshake.
// Optional feature macro: MEMORY_DUMPER_CHECKSUM_EN appends one byte holding
// the 8-bit modular sum of all data bytes sent.
module memory_dumper
   import memory_dumper_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [31:0]            base_addr,
   input  logic [COUNT_WIDTH-1:0] word_count,
   output logic                   busy,
   output logic                   done,
   output logic [31:0]            mem_out_addr,
   output logic                   mem_out_valid,
   input  logic [31:0]            mem_out_data,
   input  logic                   mem_out_ready,
   output logic [7:0]             uart_in_data,
   output logic                   uart_in_valid,
   input  logic                   uart_in_ready
);

`ifdef MEMORY_DUMPER_CHECKSUM_EN
   localparam dump_state_t TAIL = CSUM;
`else
   localparam dump_state_t TAIL = DONE;
`endif

   dump_state_t            state;
   dump_state_t            state_next;
   logic [31:0]            addr;
   logic [31:0]            word;
   logic [COUNT_WIDTH-1:0] remaining;
   logic [1:0]             byte_idx;
   logic [7:0]             cur_byte;
   logic                   last_byte;
`ifdef MEMORY_DUMPER_CHECKSUM_EN
   logic [7:0]             csum;
`endif

   assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));

   // Big-endian byte select: byte 0 is the most significant byte of the word.
   always_comb begin
      cur_byte = word[31:24];
      case (byte_idx)
         2'd0: cur_byte = word[31:24];
         2'd1: cur_byte = word[23:16];
         2'd2: cur_byte = word[15:8];
         2'd3: cur_byte = word[7:0];
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state and handshake outputs; both handshakes are owned by distinct states.
   always_comb begin
      state_next    = state;
      busy          = (state != IDLE);
      done          = 1'b0;
      mem_out_addr  = addr;
      mem_out_valid = 1'b0;
      uart_in_valid = 1'b0;
      uart_in_data  = cur_byte;
      case (state)
         IDLE: begin
            if (start) state_next = (word_count == '0) ? TAIL : REQ;
         end
         REQ: begin
            mem_out_valid = 1'b1;
            if (mem_out_ready) state_next = SEND;
         end
         SEND: begin
            uart_in_valid = 1'b1;
            if (uart_in_ready && last_byte)
               state_next = (remaining != COUNT_WIDTH'(1)) ? REQ : TAIL;
         end
`ifdef MEMORY_DUMPER_CHECKSUM_EN
         CSUM: begin
            uart_in_valid = 1'b1;
            uart_in_data  = csum;
            if (uart_in_ready) state_next = DONE;
         end
`endif
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: latch the request, capture read data, advance byte/word counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr      <= '0;
         word      <= '0;
         remaining <= '0;
         byte_idx  <= '0;
`ifdef MEMORY_DUMPER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr      <= base_addr;
                  remaining <= word_count;
`ifdef MEMORY_DUMPER_CHECKSUM_EN
                  csum      <= '0;
`endif
               end
            end
            REQ: begin
               if (mem_out_ready) begin
                  word     <= mem_out_data;
                  byte_idx <= '0;
               end
            end
            SEND: begin
               if (uart_in_ready) begin
                  byte_idx <= byte_idx + 2'd1;
`ifdef MEMORY_DUMPER_CHECKSUM_EN
                  csum     <= csum + cur_byte;
`endif
                  if (last_byte) begin
                     addr      <= addr + 32'd4;
                     remaining <= remaining - COUNT_WIDTH'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_dumper.sv
// Self-checking bench for memory_dumper: directed dumps with hand-computed
// byte streams and read addresses. Honors MEMORY_DUMPER_CHECKSUM_EN.
module tb_memory_dumper;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] base_addr;
   logic [15:0] word_count;
   logic        busy;
   logic        done;
   logic [31:0] mem_out_addr;
   logic        mem_out_valid;
   logic [31:0] mem_out_data;
   logic        mem_out_ready;
   logic [7:0]  uart_in_data;
   logic        uart_in_valid;
   logic        uart_in_ready;

   memory_dumper #(.COUNT_WIDTH(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .base_addr     (base_addr),
      .word_count    (word_count),
      .busy          (busy),
      .done          (done),
      .mem_out_addr  (mem_out_addr),
      .mem_out_valid (mem_out_valid),
      .mem_out_data  (mem_out_data),
      .mem_out_ready (mem_out_ready),
      .uart_in_data  (uart_in_data),
      .uart_in_valid (uart_in_valid),
      .uart_in_ready (uart_in_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int cyc, start_cyc, first_req_cyc, last_byte_cyc, done_cyc;
   int done_cnt, done_base, exp_count;
   int mem_lat, wait_cnt;
   int stall_left, stall_cycles;
   bit stall_arm;
   logic [31:0] req_addr;
   logic [7:0]  bytes_q[$];
   logic [7:0]  exp_b[$];
   logic [31:0] rd_q[$];
   logic [31:0] exp_r[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 32'h1122_3344;
         32'h0000_0104: return 32'hA0B0_C0D0;
         32'hFFFF_FFFC: return 32'hDEAD_BEEF;
         32'h0000_0000: return 32'h0102_0304;
         32'h0000_0200: return 32'hCAFE_F00D;
         default:       return 32'h5555_5555;
      endcase
   endfunction

   // Memory responder, UART sink and event logger, all evaluated on the falling edge.
   initial begin
      mem_out_ready = 1'b0;
      mem_out_data  = 32'hBAD0_BAD0;
      uart_in_ready = 1'b1;
      wait_cnt      = 0;
      stall_left    = 0;
      cyc           = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (mem_out_valid) begin
            if (wait_cnt == 0) req_addr = mem_out_addr;
            else if (mem_lat > 0) check("req_addr_hold", mem_out_addr, req_addr);
            if (mem_lat > 0) check("no_byte_while_req", 32'(uart_in_valid), 32'd0);
            if (wait_cnt >= mem_lat) begin
               mem_out_ready = 1'b1;
               mem_out_data  = mem_word(mem_out_addr);
            end else begin
               mem_out_ready = 1'b0;
               mem_out_data  = 32'hBAD0_BAD0;
            end
            wait_cnt++;
         end else begin
            mem_out_ready = 1'b0;
            mem_out_data  = 32'hBAD0_BAD0;
            wait_cnt      = 0;
         end

         if (stall_arm && uart_in_valid && uart_in_data == 8'h33) begin
            stall_arm  = 1'b0;
            stall_left = 5;
         end
         if (stall_left > 0) begin
            uart_in_ready = 1'b0;
            stall_left--;
            stall_cycles++;
            check("stall_valid", 32'(uart_in_valid), 32'd1);
            check("stall_data", 32'(uart_in_data), 32'h33);
         end else begin
            uart_in_ready = 1'b1;
         end

         if (mem_out_valid || uart_in_valid)
            check("hs_exclusive", 32'(mem_out_valid && uart_in_valid), 32'd0);
         if (start && !busy) start_cyc = cyc;
         if (mem_out_valid && first_req_cyc < 0) first_req_cyc = cyc;
         if (mem_out_valid && mem_out_ready) rd_q.push_back(mem_out_addr);
         if (uart_in_valid && uart_in_ready) begin
            bytes_q.push_back(uart_in_data);
            last_byte_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_with_done", 32'(busy), 32'd1);
         end
      end
   end

   task automatic kick(input logic [31:0] b, input logic [15:0] c);
      @(posedge clk); #1;
      bytes_q.delete();
      rd_q.delete();
      first_req_cyc = -1;
      done_base     = done_cnt;
      exp_count     = int'(c);
      base_addr     = b;
      word_count    = c;
      start         = 1'b1;
      @(posedge clk); #1;
      start         = 1'b0;
   endtask

   task automatic finish_dump(input string nm);
      int n;
      n = 0;
      while (done_cnt == done_base && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      check({nm, "_done_seen"}, 32'(done_cnt != done_base), 32'd1);
      repeat (2) begin @(posedge clk); #1; end
      check({nm, "_done_once"}, 32'(done_cnt - done_base), 32'd1);
      check({nm, "_idle_after"}, 32'(busy), 32'd0);
      check({nm, "_nbytes"}, 32'(bytes_q.size()), 32'(exp_b.size()));
      foreach (exp_b[i])
         if (i < bytes_q.size())
            check($sformatf("%s_byte%0d", nm, i), 32'(bytes_q[i]), 32'(exp_b[i]));
      check({nm, "_nreads"}, 32'(rd_q.size()), 32'(exp_r.size()));
      foreach (exp_r[i])
         if (i < rd_q.size())
            check($sformatf("%s_read%0d", nm, i), rd_q[i], exp_r[i]);
      if (exp_count > 0)
         check({nm, "_first_req"}, 32'(first_req_cyc), 32'(start_cyc + 1));
      if (exp_b.size() > 0)
         check({nm, "_done_pos"}, 32'(done_cyc), 32'(last_byte_cyc + 1));
      else
         check({nm, "_done_pos"}, 32'(done_cyc), 32'(start_cyc + 1));
   endtask

   initial begin
      int n;
      reset        = 1'b1;
      start        = 1'b0;
      base_addr    = '0;
      word_count   = '0;
      mem_lat      = 0;
      stall_arm    = 1'b0;
      stall_cycles = 0;
      done_cnt     = 0;
      done_cyc     = -1;
      start_cyc    = -1;
      last_byte_cyc = -1;
      first_req_cyc = -1;

      #3;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_mem_valid", 32'(mem_out_valid), 32'd0);
      check("rst_uart_valid", 32'(uart_in_valid), 32'd0);
      check("rst_mem_addr", mem_out_addr, 32'd0);
      check("rst_uart_data", 32'(uart_in_data), 32'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Basic two-word dump.
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
`ifdef MEMORY_DUMPER_CHECKSUM_EN
      exp_b.push_back(8'h8A);
`endif
      exp_r = '{32'h0000_0100, 32'h0000_0104};
      kick(32'h0000_0100, 16'd2);
      finish_dump("basic");

      // UART stall on byte 0x33.
      stall_cycles = 0;
      stall_arm    = 1'b1;
      kick(32'h0000_0100, 16'd2);
      finish_dump("stall");
      check("stall_cycles", 32'(stall_cycles), 32'd5);

      // Zero count.
      exp_b.delete();
`ifdef MEMORY_DUMPER_CHECKSUM_EN
      exp_b.push_back(8'h00);
`endif
      exp_r.delete();
      kick(32'h0000_0100, 16'd0);
      finish_dump("zero");

      // Slow memory.
      mem_lat = 7;
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
`ifdef MEMORY_DUMPER_CHECKSUM_EN
      exp_b.push_back(8'h8A);
`endif
      exp_r = '{32'h0000_0100, 32'h0000_0104};
      kick(32'h0000_0100, 16'd2);
      finish_dump("slow");
      mem_lat = 0;

      // Address wrap plus a start pulse while busy.
      exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
`ifdef MEMORY_DUMPER_CHECKSUM_EN
      exp_b.push_back(8'h42);
`endif
      exp_r = '{32'hFFFF_FFFC, 32'h0000_0000};
      kick(32'hFFFF_FFFC, 16'd2);
      n = 0;
      while (rd_q.size() < 1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      base_addr  = 32'h0000_0100;
      word_count = 16'd5;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      finish_dump("wrap");
      repeat (3) begin @(posedge clk); #1; end
      check("wrap_no_requeue_busy", 32'(busy), 32'd0);
      check("wrap_no_requeue_reads", 32'(rd_q.size()), 32'd2);

      // Reset during byte 2 of word 1, then a clean restart.
      kick(32'h0000_0100, 16'd2);
      n = 0;
      while (bytes_q.size() < 6 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("mid_offer", 32'(uart_in_data), 32'hC0);
      done_base = done_cnt;
      reset = 1'b1;
      #1;
      check("mid_rst_uart_valid", 32'(uart_in_valid), 32'd0);
      check("mid_rst_mem_valid", 32'(mem_out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("mid_no_done", 32'(done_cnt - done_base), 32'd0);
      check("mid_idle", 32'(busy), 32'd0);

      exp_b = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
`ifdef MEMORY_DUMPER_CHECKSUM_EN
      exp_b.push_back(8'hC5);
`endif
      exp_r = '{32'h0000_0200};
      kick(32'h0000_0200, 16'd1);
      finish_dump("restart");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
